// File: rtl/bp_update_ctrl.sv
// Branch pattern table sequencer: initialises the table after reset, forms gshare
// lookup indices and trains the table as in-flight branches resolve.
module bp_update_ctrl #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lookup_valid,
  input  logic [31:0]                lookup_pc,
  output logic                       lookup_ready,
  output logic [IDX_W-1:0]           tbl_rd_idx,
  input  logic                       tbl_predict,
  output logic                       pred_taken,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       tbl_wr_en,
  output logic [IDX_W-1:0]           tbl_wr_idx,
  output logic                       tbl_wr_taken,
  output logic                       tbl_wr_init,
  output logic                       mispredict,
  output logic                       init_done,
  output logic [$clog2(DEPTH):0]     q_count
);

  // state | meaning
  // INIT  | writing the init value to every table entry, one per cycle
  // RUN   | serving lookups and training the table on resolves

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_cnt;
  logic [IDX_W-1:0] ghr_spec;
  logic [IDX_W-1:0] ghr_commit;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic             upd_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic             wr_taken_q;

  logic [IDX_W-1:0] fifo_idx  [DEPTH];
  logic             fifo_pred [DEPTH];

  logic             accept;
  logic             resolve;
  logic             mis;
  logic             push;
  logic [IDX_W-1:0] ghr_commit_n;
  logic             init_wr;
  logic             unused_pc;

  assign unused_pc    = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

  assign tbl_rd_idx   = lookup_pc[IDX_W+1:2] ^ ghr_spec;
  assign pred_taken   = tbl_predict;
  assign lookup_ready = (state == RUN) && (count < CW'(DEPTH));
  assign q_count      = count;

  assign accept       = lookup_valid && lookup_ready;
  assign resolve      = (state == RUN) && res_valid && (count != '0);
  assign mis          = resolve && (fifo_pred[rptr] != res_taken);
  // a lookup landing in the same cycle as a mispredict belongs to the wrong path
  assign push         = accept && !mis;
  assign ghr_commit_n = {ghr_commit[IDX_W-2:0], res_taken};

  // the table must never see a write strobe while the block is held in reset
  assign init_wr      = (state == INIT) && rst_n;
  assign tbl_wr_en    = init_wr || upd_q;
  assign tbl_wr_init  = init_wr;
  assign tbl_wr_idx   = (state == INIT) ? init_cnt : wr_idx_q;
  assign tbl_wr_taken = wr_taken_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wptr]  <= tbl_rd_idx;
      fifo_pred[wptr] <= tbl_predict;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      init_cnt   <= '0;
      ghr_spec   <= '0;
      ghr_commit <= '0;
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      upd_q      <= 1'b0;
      wr_idx_q   <= '0;
      wr_taken_q <= 1'b0;
      mispredict <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          upd_q      <= resolve;
          mispredict <= mis;
          if (resolve) begin
            wr_idx_q   <= fifo_idx[rptr];
            wr_taken_q <= res_taken;
            ghr_commit <= ghr_commit_n;
          end
          if (mis) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            ghr_spec <= ghr_commit_n;
          end else begin
            if (push) begin
              wptr     <= wptr + 1'b1;
              ghr_spec <= {ghr_spec[IDX_W-2:0], tbl_predict};
            end
            if (resolve) rptr <= rptr + 1'b1;
            case ({push, resolve})
              2'b10:   count <= count + 1'b1;
              2'b01:   count <= count - 1'b1;
              default: count <= count;
            endcase
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: init walk, table-driven run vectors, resets.
module tb_bp_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        lookup_ready;
  logic [9:0]  tbl_rd_idx;
  logic        tbl_predict = 1'b0;
  logic        pred_taken;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic        tbl_wr_en;
  logic [9:0]  tbl_wr_idx;
  logic        tbl_wr_taken;
  logic        tbl_wr_init;
  logic        mispredict;
  logic        init_done;
  logic [2:0]  q_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_update_ctrl #(.IDX_W(10), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
    .tbl_rd_idx(tbl_rd_idx), .tbl_predict(tbl_predict), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_taken(tbl_wr_taken),
    .tbl_wr_init(tbl_wr_init), .mispredict(mispredict), .init_done(init_done),
    .q_count(q_count)
  );

  typedef struct {
    logic        lv;
    logic [31:0] pc;
    logic        pred;
    logic        rv;
    logic        rt;
    logic        e_rdy;
    logic [9:0]  e_idx;
    logic        e_wr;
    logic [9:0]  e_widx;
    logic        e_wt;
    logic        e_mis;
    logic [2:0]  e_q;
  } vec_t;

  vec_t tv [29];

  function automatic vec_t mk(logic lv, logic [31:0] pc, logic pred, logic rv, logic rt,
                              logic e_rdy, logic [9:0] e_idx, logic e_wr, logic [9:0] e_widx,
                              logic e_wt, logic e_mis, logic [2:0] e_q);
    vec_t v;
    v.lv = lv; v.pc = pc; v.pred = pred; v.rv = rv; v.rt = rt;
    v.e_rdy = e_rdy; v.e_idx = e_idx; v.e_wr = e_wr; v.e_widx = e_widx;
    v.e_wt = e_wt; v.e_mis = e_mis; v.e_q = e_q;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after reset release; checks n INIT cycles starting at index 0.
  task automatic run_init(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("init_wr_en", {31'd0, tbl_wr_en}, 32'd1);
      chk("init_wr_init", {31'd0, tbl_wr_init}, 32'd1);
      chk("init_wr_idx", {22'd0, tbl_wr_idx}, i);
      chk("init_ready", {31'd0, lookup_ready}, 32'd0);
      step();
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_q_count"}, {29'd0, q_count}, 32'd0);
    chk({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    chk({tag, "_ready"}, {31'd0, lookup_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, tbl_wr_en}, 32'd0);
    chk({tag, "_wr_idx"}, {22'd0, tbl_wr_idx}, 32'd0);
    chk({tag, "_mispredict"}, {31'd0, mispredict}, 32'd0);
  endtask

  task automatic check_run_entry();
    chk("post_init_done", {31'd0, init_done}, 32'd1);
    chk("post_init_ready", {31'd0, lookup_ready}, 32'd1);
    chk("post_init_wr_en", {31'd0, tbl_wr_en}, 32'd0);
  endtask

  initial begin
    // lv pc pred rv rt | rdy idx wr widx wt mis q
    tv[0]  = mk(1, 32'h10,  1, 0, 0,  1, 10'd4,   0, 10'd0,   0, 0, 3'd0);
    tv[1]  = mk(0, 32'h10,  0, 1, 1,  1, 10'd5,   0, 10'd0,   0, 0, 3'd1);
    tv[2]  = mk(0, 32'h10,  0, 0, 0,  1, 10'd5,   1, 10'd4,   1, 0, 3'd0);
    tv[3]  = mk(1, 32'h0,   1, 0, 0,  1, 10'd1,   0, 10'd0,   0, 0, 3'd0);
    tv[4]  = mk(1, 32'h100, 1, 0, 0,  1, 10'h43,  0, 10'd0,   0, 0, 3'd1);
    tv[5]  = mk(1, 32'h0,   1, 0, 0,  1, 10'd7,   0, 10'd0,   0, 0, 3'd2);
    tv[6]  = mk(1, 32'h0,   1, 1, 0,  1, 10'd15,  0, 10'd0,   0, 0, 3'd3);
    tv[7]  = mk(0, 32'h0,   0, 0, 0,  1, 10'd2,   1, 10'd1,   0, 1, 3'd0);
    tv[8]  = mk(0, 32'h0,   0, 0, 0,  1, 10'd2,   0, 10'd0,   0, 0, 3'd0);
    tv[9]  = mk(0, 32'h0,   0, 1, 1,  1, 10'd2,   0, 10'd0,   0, 0, 3'd0);
    tv[10] = mk(0, 32'h0,   0, 0, 0,  1, 10'd2,   0, 10'd0,   0, 0, 3'd0);
    tv[11] = mk(1, 32'h0,   0, 0, 0,  1, 10'd2,   0, 10'd0,   0, 0, 3'd0);
    tv[12] = mk(1, 32'h0,   0, 0, 0,  1, 10'd4,   0, 10'd0,   0, 0, 3'd1);
    tv[13] = mk(1, 32'h0,   0, 0, 0,  1, 10'd8,   0, 10'd0,   0, 0, 3'd2);
    tv[14] = mk(1, 32'h0,   0, 0, 0,  1, 10'd16,  0, 10'd0,   0, 0, 3'd3);
    tv[15] = mk(1, 32'h0,   0, 1, 0,  0, 10'd32,  0, 10'd0,   0, 0, 3'd4);
    tv[16] = mk(1, 32'h0,   0, 0, 0,  1, 10'd32,  1, 10'd2,   0, 0, 3'd3);
    tv[17] = mk(0, 32'h0,   0, 0, 0,  0, 10'd64,  0, 10'd0,   0, 0, 3'd4);
    tv[18] = mk(0, 32'h0,   0, 1, 0,  0, 10'd64,  0, 10'd0,   0, 0, 3'd4);
    tv[19] = mk(1, 32'h0,   1, 1, 0,  1, 10'd64,  1, 10'd4,   0, 0, 3'd3);
    tv[20] = mk(0, 32'h0,   0, 0, 0,  1, 10'd129, 1, 10'd8,   0, 0, 3'd3);
    tv[21] = mk(0, 32'h0,   0, 1, 0,  1, 10'd129, 0, 10'd0,   0, 0, 3'd3);
    tv[22] = mk(0, 32'h0,   0, 1, 0,  1, 10'd129, 1, 10'd16,  0, 0, 3'd2);
    tv[23] = mk(0, 32'h0,   0, 1, 0,  1, 10'd129, 1, 10'd32,  0, 0, 3'd1);
    tv[24] = mk(0, 32'h0,   0, 0, 0,  1, 10'd128, 1, 10'd64,  0, 1, 3'd0);
    tv[25] = mk(0, 32'h0,   0, 0, 0,  1, 10'd128, 0, 10'd0,   0, 0, 3'd0);
    tv[26] = mk(1, 32'h0,   0, 0, 0,  1, 10'd128, 0, 10'd0,   0, 0, 3'd0);
    tv[27] = mk(0, 32'h0,   0, 1, 1,  1, 10'd256, 0, 10'd0,   0, 0, 3'd1);
    tv[28] = mk(0, 32'h0,   0, 0, 0,  1, 10'd257, 1, 10'd128, 1, 1, 3'd0);

    // held in reset
    step();
    step();
    check_reset_state("rst");

    rst_n = 1'b1;
    run_init(1024);
    check_run_entry();

    for (int i = 0; i < 29; i++) begin
      lookup_valid = tv[i].lv;
      lookup_pc    = tv[i].pc;
      tbl_predict  = tv[i].pred;
      res_valid    = tv[i].rv;
      res_taken    = tv[i].rt;
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, lookup_ready}, {31'd0, tv[i].e_rdy});
      chk($sformatf("v%0d_rd_idx", i), {22'd0, tbl_rd_idx}, {22'd0, tv[i].e_idx});
      chk($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, tv[i].pred});
      chk($sformatf("v%0d_wr_en", i), {31'd0, tbl_wr_en}, {31'd0, tv[i].e_wr});
      chk($sformatf("v%0d_wr_init", i), {31'd0, tbl_wr_init}, 32'd0);
      chk($sformatf("v%0d_mispredict", i), {31'd0, mispredict}, {31'd0, tv[i].e_mis});
      chk($sformatf("v%0d_q_count", i), {29'd0, q_count}, {29'd0, tv[i].e_q});
      if (tv[i].e_wr) begin
        chk($sformatf("v%0d_wr_idx", i), {22'd0, tbl_wr_idx}, {22'd0, tv[i].e_widx});
        chk($sformatf("v%0d_wr_taken", i), {31'd0, tbl_wr_taken}, {31'd0, tv[i].e_wt});
      end
      step();
    end
    lookup_valid = 1'b0;
    res_valid    = 1'b0;

    // two entries in flight, then reset mid-RUN
    lookup_pc    = 32'h0;
    tbl_predict  = 1'b1;
    lookup_valid = 1'b1;
    step();
    step();
    lookup_valid = 1'b0;
    #1;
    chk("run2_q_count", {29'd0, q_count}, 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_run");
    step();
    rst_n = 1'b1;
    run_init(500);

    // reset again at INIT index 500
    #1;
    chk("mid_init_idx", {22'd0, tbl_wr_idx}, 32'd500);
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_init");
    step();
    rst_n = 1'b1;
    run_init(1024);
    check_run_entry();

    // history cleared by reset: index is pc bits only
    lookup_pc = 32'h10;
    #1;
    chk("post_rst_rd_idx", {22'd0, tbl_rd_idx}, 32'd4);
    chk("post_rst_q_count", {29'd0, q_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
